// File: rtl/apb4_master_pkg.sv
// Shared types and helpers for the APB4 requester and its wait-state watchdog.
package apb4_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int PPROT_W = 3;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb4_req_master_if.sv
// Command, response and APB4 signal bundle; "master" is the requester view, "slave" the environment view.
interface apb4_req_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = apb4_master_pkg::strb_width(DATA_WIDTH);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic [STRB_WIDTH-1:0] req_strb_i;
  logic [2:0]            req_prot_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_timeout_o;

  logic [ADDR_WIDTH-1:0] paddr_o;
  logic [2:0]            pprot_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_WIDTH-1:0] pwdata_o;
  logic [STRB_WIDTH-1:0] pstrb_o;
  logic                  pready_i;
  logic [DATA_WIDTH-1:0] prdata_i;
  logic                  pslverr_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    output req_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  pready_i, prdata_i, pslverr_i
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_strb_i, req_prot_i,
    input  req_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output pready_i, prdata_i, pslverr_i
  );

endinterface

// File: rtl/apb4_master_wdt.sv
// Saturating count of ACCESS cycles spent waiting on pready; flags the cycle that would reach TIMEOUT.
module apb4_master_wdt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 2);
  localparam int LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] LAST = LAST_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the waiting cycle whose increment would make the count equal TIMEOUT.
  assign timeout_o = (TIMEOUT != 0) && en_i && (cnt_q >= LAST);

endmodule

// File: rtl/apb4_req_master.sv
// APB4 requester: one valid/ready command becomes one APB transfer, answered on a valid/ready response.
module apb4_req_master
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic               clk_i,
  input logic               rst_i,
  apb4_req_master_if.master bus
);
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);

  state_e                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [PPROT_W-1:0]    pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic req_hs;
  logic wdt_en;
  logic wdt_timeout;

  assign req_hs = (state_q == IDLE) && bus.req_valid_i && req_ready_q;
  assign wdt_en = (state_q == ACCESS) && !bus.pready_i;

  apb4_master_wdt #(
    .TIMEOUT (TIMEOUT)
  ) u_wdt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (req_hs),
    .en_i      (wdt_en),
    .timeout_o (wdt_timeout)
  );

  always_comb begin
    state_d       = state_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_hs) begin
          state_d  = SETUP;
          paddr_d  = bus.req_addr_i;
          pprot_d  = bus.req_prot_i;
          pwrite_d = bus.req_write_i;
          pwdata_d = bus.req_wdata_i;
          pstrb_d  = bus.req_write_i ? bus.req_strb_i : '0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        // A late pready in the timeout cycle still completes the transfer normally.
        if (bus.pready_i) begin
          state_d       = RESP;
          rsp_err_d     = bus.pslverr_i;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !bus.pslverr_i) ? bus.prdata_i : '0;
        end else if (wdt_timeout) begin
          state_d       = RESP;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          state_d       = IDLE;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake/strobe outputs are registered decodes of the next state.
    req_ready_d = (state_d == IDLE);
    psel_d      = (state_d == SETUP) || (state_d == ACCESS);
    penable_d   = (state_d == ACCESS);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.psel_o        = psel_q;
  assign bus.penable_o     = penable_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.paddr_o       = paddr_q;
  assign bus.pprot_o       = pprot_q;
  assign bus.pwrite_o      = pwrite_q;
  assign bus.pwdata_o      = pwdata_q;
  assign bus.pstrb_o       = pstrb_q;
  assign bus.rsp_rdata_o   = rsp_rdata_q;
  assign bus.rsp_err_o     = rsp_err_q;
  assign bus.rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb4_req_master.sv
// Scenario bench for apb4_req_master; a negedge scoreboard checks every response handshake.
module tb_apb4_req_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  apb4_req_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  apb4_req_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  // Scoreboard plus protocol invariants, sampled mid-cycle.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst) begin
      checks++;
      if ((bus.penable_o && !bus.psel_o) || (bus.psel_o && bus.rsp_valid_o)) begin
        errors++;
        $display("FAIL apb_protocol psel=%b penable=%b rsp_valid=%b", bus.psel_o, bus.penable_o, bus.rsp_valid_o);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got rdata=%h err=%b tmo=%b", bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o);
        end else begin
          e = exp_q.pop_front();
          if ({bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o} !== {e.rdata, e.err, e.tmo}) begin
            errors++;
            $display("FAIL rsp_data got rdata=%h err=%b tmo=%b expected rdata=%h err=%b tmo=%b",
                     bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o, e.rdata, e.err, e.tmo);
          end else begin
            $display("rsp rdata=%h err=%b tmo=%b ok", bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o);
          end
        end
      end
    end
  end

  function automatic rsp_t mk_rsp(input logic [31:0] rdata, input logic err, input logic tmo);
    rsp_t r;
    r.rdata = rdata;
    r.err   = err;
    r.tmo   = tmo;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wdata;
    bus.req_strb_i  = strb;
    bus.req_prot_i  = prot;
  endtask

  task automatic test_reset();
    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_addr_i = '0;
    bus.req_wdata_i = '0;   bus.req_strb_i = '0;    bus.req_prot_i = '0;
    bus.rsp_ready_i = 1'b1; bus.pready_i = 1'b0;    bus.prdata_i = '0;
    bus.pslverr_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o,
         bus.paddr_o, bus.pprot_o, bus.psel_o, bus.penable_o, bus.pwrite_o, bus.pwdata_o, bus.pstrb_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got psel=%b penable=%b req_ready=%b rsp_valid=%b paddr=%h expected all 0",
               bus.psel_o, bus.penable_o, bus.req_ready_o, bus.rsp_valid_o, bus.paddr_o);
    end
    cyc();
    cyc();
    rst = 1'b0;
    checks++;
    if (bus.req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready got %b expected 0", bus.req_ready_o);
    end
    cyc();
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_after got %b expected 1", bus.req_ready_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_write();
    bus.rsp_ready_i = 1'b1;
    bus.pready_i    = 1'b1;
    send_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    exp_q.push_back(mk_rsp(32'h0, 1'b0, 1'b0));
    cyc();
    bus.req_valid_i = 1'b0;
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.req_ready_o} !== 4'b1010) begin
      errors++;
      $display("FAIL wr_setup got psel/penable/pwrite/req_ready=%b%b%b%b expected 1010",
               bus.psel_o, bus.penable_o, bus.pwrite_o, bus.req_ready_o);
    end
    checks++;
    if ({bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.pprot_o} !== {32'h10, 32'hDEADBEEF, 4'hF, 3'b010}) begin
      errors++;
      $display("FAIL wr_fields got paddr=%h pwdata=%h pstrb=%h pprot=%h expected 10 deadbeef f 2",
               bus.paddr_o, bus.pwdata_o, bus.pstrb_o, bus.pprot_o);
    end
    cyc();
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o} !== 3'b110 || bus.paddr_o !== 32'h10) begin
      errors++;
      $display("FAIL wr_access got psel=%b penable=%b rsp_valid=%b paddr=%h expected 1 1 0 10",
               bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.paddr_o);
    end
    cyc();
    checks++;
    if ({bus.rsp_valid_o, bus.psel_o, bus.penable_o} !== 3'b100) begin
      errors++;
      $display("FAIL wr_rsp_latency got rsp_valid=%b psel=%b penable=%b expected 1 0 0",
               bus.rsp_valid_o, bus.psel_o, bus.penable_o);
    end
    cyc();
    checks++;
    if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL wr_back_idle got rsp_valid=%b req_ready=%b expected 0 1", bus.rsp_valid_o, bus.req_ready_o);
    end
    $display("test_write done");
  endtask

  task automatic test_read_wait();
    int en_cycles = 0;
    bus.pready_i = 1'b0;
    send_req(1'b0, 32'h04, 32'h5555AAAA, 4'hF, 3'b000);
    exp_q.push_back(mk_rsp(32'h12345678, 1'b0, 1'b0));
    cyc();
    bus.req_valid_i = 1'b0;
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.pwrite_o} !== 3'b100 || bus.pstrb_o !== 4'h0) begin
      errors++;
      $display("FAIL rd_setup got psel=%b penable=%b pwrite=%b pstrb=%h expected 1 0 0 0",
               bus.psel_o, bus.penable_o, bus.pwrite_o, bus.pstrb_o);
    end
    cyc();
    for (int i = 0; i < 4; i++) begin
      if (bus.penable_o === 1'b1) en_cycles++;
      checks++;
      if (bus.paddr_o !== 32'h04 || bus.pstrb_o !== 4'h0) begin
        errors++;
        $display("FAIL rd_addr_stable got paddr=%h pstrb=%h expected 4 0", bus.paddr_o, bus.pstrb_o);
      end
      if (i == 3) begin
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'h12345678;
      end
      cyc();
    end
    checks++;
    if (en_cycles !== 4 || bus.rsp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_wait_penable got penable_cycles=%0d rsp_valid=%b expected 4 1", en_cycles, bus.rsp_valid_o);
    end
    bus.pready_i = 1'b0;
    bus.prdata_i = '0;
    cyc();
    $display("test_read_wait done");
  endtask

  task automatic test_slverr();
    bus.pready_i  = 1'b1;
    bus.pslverr_i = 1'b1;
    bus.prdata_i  = 32'hAAAA5555;
    send_req(1'b0, 32'h20, 32'h0, 4'h0, 3'b001);
    exp_q.push_back(mk_rsp(32'h0, 1'b1, 1'b0));
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b110 || bus.rsp_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL slverr_rsp got valid=%b err=%b tmo=%b rdata=%h expected 1 1 0 0",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o, bus.rsp_rdata_o);
    end
    bus.pslverr_i = 1'b0;
    bus.pready_i  = 1'b0;
    bus.prdata_i  = '0;
    cyc();
    $display("test_slverr done");
  endtask

  task automatic test_timeout();
    int n = 0;
    bus.pready_i = 1'b0;
    send_req(1'b0, 32'h30, 32'h0, 4'h0, 3'b000);
    exp_q.push_back(mk_rsp(32'h0, 1'b1, 1'b1));
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    while (bus.psel_o === 1'b1 && bus.penable_o === 1'b1 && n < 20) begin
      n++;
      cyc();
    end
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL timeout_cycles got %0d ACCESS cycles expected 8", n);
    end
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b111) begin
      errors++;
      $display("FAIL timeout_rsp got valid=%b err=%b tmo=%b expected 1 1 1",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o);
    end
    cyc();

    send_req(1'b0, 32'h34, 32'h0, 4'h0, 3'b000);
    exp_q.push_back(mk_rsp(32'hCAFEF00D, 1'b0, 1'b0));
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bus.penable_o !== 1'b1) begin
        errors++;
        $display("FAIL late_ready_access cycle %0d got penable=%b expected 1", i, bus.penable_o);
      end
      if (i == 8) begin
        bus.pready_i = 1'b1;
        bus.prdata_i = 32'hCAFEF00D;
      end
      cyc();
    end
    checks++;
    if ({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o} !== 3'b100) begin
      errors++;
      $display("FAIL late_ready_rsp got valid=%b err=%b tmo=%b expected 1 0 0",
               bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o);
    end
    bus.pready_i = 1'b0;
    bus.prdata_i = '0;
    cyc();
    $display("test_timeout done");
  endtask

  task automatic test_backpressure();
    bus.rsp_ready_i = 1'b0;
    bus.pready_i    = 1'b1;
    bus.prdata_i    = 32'h0BADF00D;
    send_req(1'b0, 32'h40, 32'h0, 4'h0, 3'b000);
    exp_q.push_back(mk_rsp(32'h0BADF00D, 1'b0, 1'b0));
    cyc();
    send_req(1'b1, 32'h44, 32'h11111111, 4'hF, 3'b000);
    cyc();
    cyc();
    bus.prdata_i = 32'h0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.rsp_valid_o, bus.req_ready_o, bus.psel_o} !== 3'b100 || bus.rsp_rdata_o !== 32'h0BADF00D) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rsp_valid=%b req_ready=%b psel=%b rdata=%h expected 1 0 0 0badf00d",
                 i, bus.rsp_valid_o, bus.req_ready_o, bus.psel_o, bus.rsp_rdata_o);
      end
      cyc();
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    cyc();
    checks++;
    if ({bus.rsp_valid_o, bus.req_ready_o, bus.psel_o} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release got rsp_valid=%b req_ready=%b psel=%b expected 0 1 0",
               bus.rsp_valid_o, bus.req_ready_o, bus.psel_o);
    end
    bus.pready_i = 1'b0;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready_i = 1'b1;
    bus.pready_i    = 1'b0;
    send_req(1'b0, 32'h50, 32'h0, 4'h0, 3'b000);
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    checks++;
    if ({bus.psel_o, bus.penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre_access got psel=%b penable=%b expected 1 1", bus.psel_o, bus.penable_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async got psel=%b penable=%b rsp_valid=%b req_ready=%b expected 0 0 0 0",
               bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o);
    end
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (bus.req_ready_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ready got req_ready=%b rsp_valid=%b expected 1 0", bus.req_ready_o, bus.rsp_valid_o);
    end
    bus.pready_i = 1'b1;
    send_req(1'b1, 32'h60, 32'h01020304, 4'h3, 3'b000);
    exp_q.push_back(mk_rsp(32'h0, 1'b0, 1'b0));
    cyc();
    bus.req_valid_i = 1'b0;
    cyc();
    cyc();
    checks++;
    if (bus.rsp_valid_o !== 1'b1 || bus.pstrb_o !== 4'h3 || bus.paddr_o !== 32'h60) begin
      errors++;
      $display("FAIL rst_next_write got rsp_valid=%b pstrb=%h paddr=%h expected 1 3 60",
               bus.rsp_valid_o, bus.pstrb_o, bus.paddr_o);
    end
    cyc();
    bus.pready_i = 1'b0;
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    cyc();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending responses expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
